regfile_2r1w_sb: RTL
====================

Name: regfile_2r1w_sb

Overview:
- Architectural integer register file for the core: 32 x N_BITS storage, two read ports for the decode stage, one write port.
- The write port is driven by the write stage's registered rf control packet and data.
- Integrated per-register scoreboard tracks in-flight writes, giving decode a read-after-write hazard stall.
- Sits between the W stage (writer) and the D stage (reader/issuer).

Parameters:
- N_BITS, 32, register data width (from core_types_pkg).
- N_REGS, 32, number of architectural registers; address width is $clog2(N_REGS).
- SB_CNT_W, 2, width of each per-register in-flight counter; max in-flight writes per register = 2**SB_CNT_W-1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write-back valid, from the W stage rf control packet.
- wr_addr  in  5  write-back destination register.
- wr_data  in  N_BITS  write-back data, from W stage data_out.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_data  out  N_BITS  read port 1 data, combinational.
- rs2_data  out  N_BITS  read port 2 data, combinational.
- iss_en  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  5  destination of the issuing instruction.
- rs1_busy  out  1  rs1_addr has a nonzero in-flight count.
- rs2_busy  out  1  rs2_addr has a nonzero in-flight count.
- stall  out  1  rs1_busy | rs2_busy | (iss_en and iss_rd counter saturated).
- sb_err  out  1  sticky: a write-back arrived for a register whose counter was 0.

Behaviour:
- Reset (async, rst_n low): all registers = 0, all counters = 0, sb_err = 0. Outputs therefore read 0, busy/stall = 0. Reset asserted mid-operation discards all in-flight tracking immediately.
- Register x0: reads always 0. Writes to x0 are ignored. Issues to x0 are ignored (counter never changes). x0 is never busy.
- Write: on a rising clk edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Latency is one cycle without bypass.
- Read: rs*_data = reg[rs*_addr], purely combinational, no read latency.
- Scoreboard counter cnt[r], updated per clock edge:
  - inc = iss_en & iss_rd==r & r!=0 & cnt[r] != max.
  - dec = wr_en & wr_addr==r & r!=0 & cnt[r] != 0.
  - inc&dec: unchanged. inc only: +1. dec only: -1.
  - Saturation: issue to a saturated counter is dropped and stall=1 that cycle; the issuer must hold and retry.
  - Underflow: write-back when cnt[r]==0 leaves cnt at 0, still performs the data write, and sets sb_err=1 until reset.
- Busy: rs1_busy = (cnt[rs1_addr]!=0). With RF_BYPASS_EN, a write-back in the same cycle that brings cnt from 1 to 0 on that address deasserts busy combinationally. rs2 is symmetric.
- stall is combinational from current inputs/state. No hold logic inside the block.
- Simultaneous write-back and issue to the same register: data written, counter unchanged, busy stays asserted.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Write-through bypass: if wr_en & wr_addr!=0 & wr_addr==rs*_addr, rs*_data = wr_data in the same cycle.
  - The busy computation uses the post-write-back count as described above.
- Undefined:
  - Read data reflects the value only on the cycle after the write edge.
  - Busy reflects the registered count only, so the reader sees a one-cycle-longer stall.

Test Plan:
- Reset, then read all 32 addresses -> all 0. Write x0=32'hDEADBEEF, read x0 -> 0.
- Write x5=32'h1234_5678, read rs1=x5, rs2=x5 next cycle -> both 32'h1234_5678. With RF_BYPASS_EN, same-cycle read returns it; without, the same-cycle read returns the old value 0.
- Issue x7, then read rs1=x7 -> rs1_busy=1, stall=1. Write-back x7 -> bypass build: busy=0 that cycle; non-bypass: busy=0 next cycle.
- Issue x3 three times (SB_CNT_W=2) -> cnt=3, fourth issue gives stall=1 and cnt stays 3. Three write-backs -> cnt=0. Issue+write-back x3 same cycle at cnt=1 -> cnt stays 1.
- Write-back x9 with cnt=0 -> sb_err=1 and reg x9 updated. sb_err persists until rst_n pulse.
- Issue x4 twice, assert rst_n low mid-cycle (async) -> busy/stall drop immediately, x4 reads 0, sb_err=0.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb
//   Architectural integer register file (N_REGS x N_BITS) with two
//   combinational read ports, one write port fed by the W stage, and a
//   per-register scoreboard of in-flight writes giving decode a RAW stall.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   - same-cycle write-through to the read ports, and busy uses
//                 the post-write-back count.
//     undefined - reads and busy reflect registered state only.
//
// Ports
//   clk, rst_n           core clock, async active-low reset
//   wr_en/wr_addr/wr_data write-back from W stage
//   rs1_addr/rs2_addr     read addresses; rs1_data/rs2_data combinational
//   iss_en/iss_rd         decode issues an instruction writing iss_rd
//   rs1_busy/rs2_busy     read register has writes in flight
//   stall                 RAW hazard or issue target counter saturated
//   sb_err                sticky: write-back to a register with no write in flight
module regfile_2r1w_sb #(
  parameter int N_BITS   = 32,
  parameter int N_REGS   = 32,
  parameter int SB_CNT_W = 2,
  localparam int AW      = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [N_BITS-1:0] wr_data,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [N_BITS-1:0] rs1_data,
  output logic [N_BITS-1:0] rs2_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              stall,
  output logic              sb_err
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = {SB_CNT_W{1'b1}};

  logic [N_BITS-1:0]   regs_q [N_REGS];
  logic [N_BITS-1:0]   regs_d [N_REGS];
  logic [SB_CNT_W-1:0] cnt_q  [N_REGS];
  logic [SB_CNT_W-1:0] cnt_d  [N_REGS];
  logic                sb_err_q, sb_err_d;

  logic wr_vld;
  assign wr_vld = wr_en && (wr_addr != '0);

  // Next state: data write, per-register counters, sticky underflow flag.
  // Entry 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    logic inc, dec;
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    inc      = 1'b0;
    dec      = 1'b0;
    if (wr_vld) regs_d[wr_addr] = wr_data;
    for (int r = 1; r < N_REGS; r++) begin
      inc = iss_en && (iss_rd == AW'(r)) && (cnt_q[r] != CNT_MAX);
      dec = wr_en && (wr_addr == AW'(r)) && (cnt_q[r] != '0);
      if (inc && !dec)      cnt_d[r] = cnt_q[r] + 1'b1;
      else if (dec && !inc) cnt_d[r] = cnt_q[r] - 1'b1;
    end
    if (wr_vld && (cnt_q[wr_addr] == '0)) sb_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_REGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

`ifdef RF_BYPASS_EN
  // Busy drops in the same cycle as the write-back that retires the last
  // in-flight write, unless an issue to the same register refills it.
  function automatic logic busy_f(input logic [AW-1:0] a, input logic [SB_CNT_W-1:0] c);
    logic wr_hit, iss_hit;
    wr_hit  = wr_en && (wr_addr == a) && (a != '0);
    iss_hit = iss_en && (iss_rd == a);
    return (c != '0) && !((c == SB_CNT_W'(1)) && wr_hit && !iss_hit);
  endfunction

  assign rs1_data = (wr_vld && (wr_addr == rs1_addr)) ? wr_data : regs_q[rs1_addr];
  assign rs2_data = (wr_vld && (wr_addr == rs2_addr)) ? wr_data : regs_q[rs2_addr];
  assign rs1_busy = busy_f(rs1_addr, cnt_q[rs1_addr]);
  assign rs2_busy = busy_f(rs2_addr, cnt_q[rs2_addr]);
`else
  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];
  assign rs1_busy = (cnt_q[rs1_addr] != '0);
  assign rs2_busy = (cnt_q[rs2_addr] != '0);
`endif

  // A saturated target drops the issue; the issuer must hold and retry.
  // cnt_q[0] never leaves zero, so x0 is never busy nor saturated.
  assign stall  = rs1_busy || rs2_busy || (iss_en && (cnt_q[iss_rd] == CNT_MAX));
  assign sb_err = sb_err_q;

endmodule
